uart_rx_oversample: RTL
=======================

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 Parameter NB_DATA, default 8, data bits per frame (LSB first).
REQ-002 Parameter N_TICK, default 16, i_tick pulses per bit period (oversampling ratio, even, >=4).
REQ-003 Parameter SB_TICK, default 16, i_tick pulses for the stop bit (one stop bit = N_TICK).
REQ-004 i_clk  input  1  system clock; single clock domain.
REQ-005 i_reset  input  1  reset, asynchronous, active-low.
REQ-006 i_tick  input  1  single-cycle oversampling strobe from the existing baudrate tick generator, N_TICK per bit.
REQ-007 i_rx  input  1  serial line, idle high, asynchronous to i_clk.
REQ-008 o_data  output  NB_DATA  last correctly received byte, held until next good frame.
REQ-009 o_valid  output  1  one-cycle pulse: o_data updated this cycle.
REQ-010 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer (reset value 1); all FSM decisions use the synchronized value rx_s.
REQ-012 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH; tick counter ceil(log2(max(N_TICK,SB_TICK))) bits, bit counter ceil(log2(NB_DATA+1)) bits.
REQ-013 IDLE: rx_s==0 (on any clock, tick not required) -> START, tick counter cleared.
REQ-014 START: on each i_tick increment counter; when counter==N_TICK/2-1 at a tick: rx_s==0 -> DATA with counters cleared, rx_s==1 -> IDLE (glitch rejected, no output).
REQ-015 DATA: on each i_tick increment; at counter==N_TICK-1 sample rx_s into MSB of shift register (shift right), clear counter, increment bit counter; after NB_DATA-th sample -> STOP.
REQ-016 STOP: at counter==SB_TICK-1 on a tick, sample rx_s: 1 -> o_data<=shift register, o_valid=1 next cycle, -> IDLE; 0 -> o_frame_err=1 next cycle, o_data unchanged, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rx_s==1, then -> IDLE (a held-low break yields exactly one o_frame_err).
REQ-018 Counters SHALL advance only on cycles with i_tick=1; i_tick held low freezes FSM except IDLE start detection and WAIT_HIGH exit.
REQ-019 o_valid and o_frame_err SHALL never assert in the same cycle and SHALL be registered outputs.
REQ-020 Latency: o_valid asserts exactly one i_clk after the clock edge on which the stop-bit sample tick is seen.
REQ-021 A new start bit SHALL be accepted in the cycle after returning to IDLE (back-to-back frames, no gap required).

Reset
REQ-022 While i_reset==0: state=IDLE, counters=0, shift register=0, o_data=0, o_valid=0, o_frame_err=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no o_valid/o_frame_err pulse; after release, reception restarts from IDLE on the next low rx_s.

Structure
REQ-024 Shared package/header holds state encoding localparams (ST_IDLE..ST_WAIT_HIGH, 3-bit) and default NB_DATA/N_TICK/SB_TICK constants used by the transmitter side too.
REQ-025 One sub-module: sync_2ff (2-flop synchronizer, parameterized reset value); tick generation stays external.
REQ-026 Top-level pairing with the baudrate tick generator SHALL be a separate wrapper mirroring the transmit wrapper; not part of this block.

Verification
REQ-027 Frame 0xA5 (start, 10100101 LSB first, stop=1), i_tick every 4th clock -> o_data=0xA5, single o_valid pulse, o_frame_err=0.
REQ-028 i_rx low for 3 ticks then high -> no o_valid, no o_frame_err, FSM back in IDLE; then frame 0x3C -> o_data=0x3C.
REQ-029 Frame 0x5A with stop bit 0, line held low 40 ticks -> exactly one o_frame_err, o_data keeps previous 0x3C, no o_valid until line high and a new good frame.
REQ-030 Back-to-back 0x00 then 0xFF, no idle gap -> two o_valid pulses, o_data=0x00 then 0xFF.
REQ-031 i_reset asserted during DATA bit 4 of 0x81, released, then frame 0x7E -> no pulse for 0x81, o_data=0x7E with one o_valid.
REQ-032 Random bytes with ±3% baud mismatch (tick period scaled) -> 1000 frames received error-free.

Source files
------------

// File: rtl/uart_rx_oversample_pkg.sv
// Shared UART definitions: frame defaults and receiver state encoding.
package uart_rx_oversample_pkg;

    // Frame defaults shared with the transmit side.
    localparam int unsigned NB_DATA_DEF = 8;
    localparam int unsigned N_TICK_DEF  = 16;
    localparam int unsigned SB_TICK_DEF = 16;

    // Receiver FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Larger of two sizes, used to size the shared tick counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Receive-side result bus: received byte plus valid / framing-error strobes.
interface uart_rx_oversample_if
    import uart_rx_oversample_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF
);

    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic               o_frame_err;

    // Receiver drives the bus.
    modport master (
        output o_data,
        output o_valid,
        output o_frame_err
    );

    // Consumer observes the bus.
    modport slave (
        input o_data,
        input o_valid,
        input o_frame_err
    );

endinterface

// File: rtl/uart_rx_oversample_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    // Two register stages; both load RST_VAL while reset is held.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver with oversampling: start-bit mid-point check, LSB-first
// data shift, stop-bit check with framing-error reporting and break hold-off.
module uart_rx_oversample
    import uart_rx_oversample_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF,
    parameter int unsigned N_TICK  = N_TICK_DEF,
    parameter int unsigned SB_TICK = SB_TICK_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic                  i_rx,
    uart_rx_oversample_if.master  rx_bus
);

    localparam int unsigned TICK_W = $clog2(max_u(N_TICK, SB_TICK));
    localparam int unsigned BIT_W  = $clog2(NB_DATA + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(N_TICK / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_BIT  = TICK_W'(N_TICK - 1);
    localparam logic [TICK_W-1:0] TICK_STOP = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NB_DATA - 1);

    logic               rx_s;
    rx_state_e          state_q;
    logic [TICK_W-1:0]  tick_q;
    logic [BIT_W-1:0]   bit_q;
    logic [NB_DATA-1:0] shift_q;
    logic [NB_DATA-1:0] data_q;
    logic               valid_q;
    logic               ferr_q;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    // Receive FSM with counters, shift register and registered strobes.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        tick_q  <= '0;
                    end
                end
                ST_START: begin
                    if (i_tick) begin
                        if (tick_q == TICK_MID) begin
                            tick_q <= '0;
                            bit_q  <= '0;
                            // A start bit gone high by mid-bit is a glitch.
                            state_q <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_tick) begin
                        if (tick_q == TICK_BIT) begin
                            tick_q  <= '0;
                            shift_q <= {rx_s, shift_q[NB_DATA-1:1]};
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == BIT_LAST) begin
                                state_q <= ST_STOP;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (i_tick) begin
                        if (tick_q == TICK_STOP) begin
                            tick_q <= '0;
                            if (rx_s) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= ST_WAIT_HIGH;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    // Hold off through a break so it reports only once.
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_bus.o_data      = data_q;
    assign rx_bus.o_valid     = valid_q;
    assign rx_bus.o_frame_err = ferr_q;

endmodule
